// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter and sequencer for the shared data RAM.
// Port A (CPU datapath) and port B (loader) are serialised onto one RAM with
// multi-cycle write (WR) and read (RD1/RD2) sequences. Out-of-range accesses
// complete with an error and never touch the RAM.
module ram_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_LAST   = 4055
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  csRAM,
    output logic                  weRAM
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_LAST);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD1,
        RD2,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic                    prio_reg;      // 0: A wins a tie, 1: B wins a tie
    logic                    port_reg;      // granted port: 0 = A, 1 = B
    logic                    we_reg;
    logic                    err_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg [2];

    logic                    grant_any;
    logic                    grant_b;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_err;
    logic                    drive_en;

    // Round-robin grant and command mux for the requester sampled in IDLE
    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = b_req & (~a_req | prio_reg);
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_err   = (sel_addr > LAST_ADDR);
    end

    // Next-state logic; every access funnels through DONE and back to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    if (sel_err)
                        state_next = DONE;
                    else if (sel_we)
                        state_next = WR;
                    else
                        state_next = RD1;
                end
            end
            WR:      state_next = DONE;
            RD1:     state_next = RD2;
            RD2:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore decode of the RAM strobes and the data-bus enable
    always_comb begin
        csRAM    = 1'b0;
        weRAM    = 1'b0;
        drive_en = 1'b0;
        case (state_reg)
            WR: begin
                csRAM    = 1'b1;
                weRAM    = 1'b1;
                drive_en = 1'b1;
            end
            RD1, RD2: csRAM = 1'b1;
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Latch the granted command; the pointer always favours the other port next
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg  <= 1'b0;
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (state_reg == IDLE && grant_any) begin
            prio_reg  <= ~grant_b;
            port_reg  <= grant_b;
            we_reg    <= sel_we;
            err_reg   <= sel_err;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
        end
    end

    assign address = addr_reg;
    assign data    = drive_en ? wdata_reg : {DATA_WIDTH{1'bz}};

    // Per-port read-data holding registers, loaded only from the RD2 bus value
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        always_ff @(posedge clk) begin
            if (reset)
                rdata_reg[gi] <= '0;
            else if (state_reg == RD2 && port_reg == 1'(gi) && !we_reg)
                rdata_reg[gi] <= data;
        end
    end

    assign a_ack   = (state_reg == DONE) && (port_reg == 1'b0);
    assign b_ack   = (state_reg == DONE) && (port_reg == 1'b1);
    assign a_err   = a_ack & err_reg;
    assign b_err   = b_ack & err_reg;
    assign a_rdata = rdata_reg[0];
    assign b_rdata = rdata_reg[1];

endmodule
